instr_refill_ctrl: RTL and testbench

//  Instruction-cache miss/refill initiator. Accepts a fetch miss and issues one

---
 rtl/instr_refill_ctrl.sv | 176 +++++++++++++++++
 tb/tb_instr_refill_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_refill_ctrl.sv
// ---------------------------------------------------------------------------
// instr_refill_ctrl
//
// Instruction-cache miss/refill initiator. A fetch miss is latched, one
// cache-line read is issued to instruction main memory, and the returned
// line is handed to the I-cache arrays together with the instruction word
// that caused the miss. A watchdog re-issues the read if memory stays silent,
// and after a bounded number of re-requests the refill is abandoned with an
// error pulse.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_miss_req          fetch miss, held by the requester until o_refill_valid
//   i_miss_addr         byte address of the missed fetch (4-byte aligned)
//   o_busy              refill in progress, stalls fetch
//   o_mem_read_req      one-cycle read request to instruction memory
//   o_mem_read_address  line-aligned read address
//   i_mem_read_done     memory response strobe, line valid on i_cache_line
//   i_cache_line        returned line, word 0 in the low bits
//   o_refill_valid      one-cycle pulse: refill line/addr/instr are valid
//   o_refill_addr       line-aligned address of the refilled line
//   o_refill_line       captured line
//   o_refill_instr      missed instruction word taken from the line
//   o_refill_err        one-cycle pulse: retries exhausted, nothing returned
// ---------------------------------------------------------------------------
module instr_refill_ctrl #(
  parameter int ADDR_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int TIMEOUT          = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_miss_req,
  input  logic [ADDR_WIDTH-1:0]       i_miss_addr,
  output logic                        o_busy,
  output logic                        o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
  output logic                        o_refill_valid,
  output logic [ADDR_WIDTH-1:0]       o_refill_addr,
  output logic [CACHE_LINE_WIDTH-1:0] o_refill_line,
  output logic [31:0]                 o_refill_instr,
  output logic                        o_refill_err
);

  localparam int LINE_BYTES  = CACHE_LINE_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int SEL_BITS    = $clog2(CACHE_LINE_WIDTH);
  localparam int WD_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RT_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [RT_W-1:0]       RT_MAX    = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_ERR
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [WD_W-1:0]               r_wd;
  logic [RT_W-1:0]               r_retry;
  logic [OFFSET_BITS-3:0]        r_word_idx;
  logic                          w_wd_expired;
  logic                          w_take_done;
  logic [SEL_BITS-1:0]           w_bit_sel;

  logic                          r_busy;
  logic                          r_req;
  logic [ADDR_WIDTH-1:0]         r_mem_addr;
  logic                          r_valid;
  logic [ADDR_WIDTH-1:0]         r_refill_addr;
  logic [CACHE_LINE_WIDTH-1:0]   r_line;
  logic [31:0]                   r_instr;
  logic                          r_err;

  // A response is only accepted while waiting for one; strays elsewhere are dropped.
  assign w_take_done  = (r_state == S_WAIT) && i_mem_read_done;
  assign w_wd_expired = (r_state == S_WAIT) && (r_wd == WD_LAST);
  // Bit offset of the missed 32-bit word inside the line.
  assign w_bit_sel    = SEL_BITS'({r_word_idx, 5'b00000});

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode. A response arriving on the watchdog's last cycle
  // still counts, so done is checked before expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_miss_req) w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (i_mem_read_done) begin
          w_next = S_FILL;
        end else if (w_wd_expired) begin
          w_next = (r_retry < RT_MAX) ? S_REQ : S_ERR;
        end
      end
      S_FILL: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Watchdog and retry bookkeeping. The watchdog only runs in WAIT, so every
  // (re)request starts a fresh timeout window; the retry count survives
  // re-requests and is cleared once the refill resolves either way.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd    <= '0;
      r_retry <= '0;
    end else begin
      r_wd <= (r_state == S_WAIT) ? r_wd + 1'b1 : '0;
      if (r_state == S_FILL || r_state == S_ERR) begin
        r_retry <= '0;
      end else if (w_wd_expired && !i_mem_read_done && (r_retry < RT_MAX)) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  // Registered outputs. Strobes are decoded from the next state so they line
  // up with the state they describe; the refill payload is captured on the
  // accepted response and held until the following refill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy        <= 1'b0;
      r_req         <= 1'b0;
      r_mem_addr    <= '0;
      r_word_idx    <= '0;
      r_valid       <= 1'b0;
      r_refill_addr <= '0;
      r_line        <= '0;
      r_instr       <= '0;
      r_err         <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_req   <= (w_next == S_REQ);
      r_valid <= (w_next == S_FILL);
      r_err   <= (w_next == S_ERR);
      if (r_state == S_IDLE && i_miss_req) begin
        r_mem_addr <= i_miss_addr & LINE_MASK;
        r_word_idx <= i_miss_addr[OFFSET_BITS-1:2];
      end
      if (w_take_done) begin
        r_line        <= i_cache_line;
        r_instr       <= i_cache_line[w_bit_sel +: 32];
        r_refill_addr <= r_mem_addr;
      end
    end
  end

  assign o_busy             = r_busy;
  assign o_mem_read_req     = r_req;
  assign o_mem_read_address = r_mem_addr;
  assign o_refill_valid     = r_valid;
  assign o_refill_addr      = r_refill_addr;
  assign o_refill_line      = r_line;
  assign o_refill_instr     = r_instr;
  assign o_refill_err       = r_err;

endmodule

// File: tb/tb_instr_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_refill_ctrl
//
// Directed bench for instr_refill_ctrl: normal refill, top-word select,
// single retry, retry exhaustion, stray/late responses and mid-refill reset.
// ---------------------------------------------------------------------------
module tb_instr_refill_ctrl;

  logic         clk;
  logic         rst;
  logic         missReq;
  logic [63:0]  missAddr;
  logic         busy;
  logic         memReadReq;
  logic [63:0]  memReadAddress;
  logic         memReadDone;
  logic [255:0] cacheLine;
  logic         refillValid;
  logic [63:0]  refillAddr;
  logic [255:0] refillLine;
  logic [31:0]  refillInstr;
  logic         refillErr;

  int checkCount = 0;
  int failCount  = 0;
  int reqCount   = 0;
  int validCount = 0;
  int errCount   = 0;

  logic [255:0] lineA, lineB, lineC, lineE, lineF, lineJunk;

  instr_refill_ctrl dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_miss_req         (missReq),
    .i_miss_addr        (missAddr),
    .o_busy             (busy),
    .o_mem_read_req     (memReadReq),
    .o_mem_read_address (memReadAddress),
    .i_mem_read_done    (memReadDone),
    .i_cache_line       (cacheLine),
    .o_refill_valid     (refillValid),
    .o_refill_addr      (refillAddr),
    .o_refill_line      (refillLine),
    .o_refill_instr     (refillInstr),
    .o_refill_err       (refillErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line whose word k holds base+k.
  function automatic logic [255:0] makeLine(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic applyStimulus(input logic miss, input logic [63:0] addr,
                               input logic done, input logic [255:0] line);
    missReq     = miss;
    missAddr    = addr;
    memReadDone = done;
    cacheLine   = line;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge and tallying pulses.
  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      reqCount   += int'(memReadReq);
      validCount += int'(refillValid);
      errCount   += int'(refillErr);
    end
  endtask

  task automatic clearCounts();
    reqCount   = 0;
    validCount = 0;
    errCount   = 0;
  endtask

  initial begin
    lineA = makeLine(32'hA000_0000);
    lineB = makeLine(32'hB000_0000);
    lineB[255:224] = 32'hDEAD_BEEF;
    lineC = makeLine(32'hC000_0000);
    lineE = makeLine(32'hE000_0000);
    lineF = makeLine(32'hF000_0000);
    lineJunk = makeLine(32'h5555_0000);

    $display("[TB] reset");
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(3);
    checkOutput("rst_busy",   256'(busy), 256'd0);
    checkOutput("rst_req",    256'(memReadReq), 256'd0);
    checkOutput("rst_maddr",  256'(memReadAddress), 256'd0);
    checkOutput("rst_valid",  256'(refillValid), 256'd0);
    checkOutput("rst_raddr",  256'(refillAddr), 256'd0);
    checkOutput("rst_line",   refillLine, 256'd0);
    checkOutput("rst_instr",  256'(refillInstr), 256'd0);
    checkOutput("rst_err",    256'(refillErr), 256'd0);
    rst = 1'b0;
    runCycles(1);

    $display("[TB] basic refill 0x1044");
    clearCounts();
    applyStimulus(1'b1, 64'h1044, 1'b0, '0);
    runCycles(1);
    checkOutput("t1_req",   256'(memReadReq), 256'd1);
    checkOutput("t1_maddr", 256'(memReadAddress), 256'h1040);
    checkOutput("t1_busy",  256'(busy), 256'd1);
    runCycles(1);
    checkOutput("t1_req_once", 256'(memReadReq), 256'd0);
    applyStimulus(1'b1, 64'h1044, 1'b1, lineA);
    runCycles(1);
    applyStimulus(1'b1, 64'h1044, 1'b0, '0);
    checkOutput("t1_valid", 256'(refillValid), 256'd1);
    checkOutput("t1_instr", 256'(refillInstr), 256'hA000_0001);
    checkOutput("t1_raddr", 256'(refillAddr), 256'h1040);
    checkOutput("t1_line",  refillLine, lineA);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    checkOutput("t1_valid_pulse", 256'(refillValid), 256'd0);
    checkOutput("t1_idle",  256'(busy), 256'd0);
    checkOutput("t1_reqs",  256'(reqCount), 256'd1);
    runCycles(2);

    $display("[TB] top word 0x20FC, address change while busy");
    applyStimulus(1'b1, 64'h20FC, 1'b0, '0);
    runCycles(1);
    checkOutput("t2_maddr", 256'(memReadAddress), 256'h20E0);
    applyStimulus(1'b1, 64'h9999_0000, 1'b0, '0);
    runCycles(1);
    applyStimulus(1'b1, 64'h9999_0000, 1'b1, lineB);
    runCycles(1);
    applyStimulus(1'b1, 64'h9999_0000, 1'b0, '0);
    checkOutput("t2_valid", 256'(refillValid), 256'd1);
    checkOutput("t2_instr", 256'(refillInstr), 256'hDEAD_BEEF);
    checkOutput("t2_raddr", 256'(refillAddr), 256'h20E0);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(2);

    $display("[TB] one timeout then response");
    clearCounts();
    applyStimulus(1'b1, 64'h3008, 1'b0, '0);
    runCycles(1);
    runCycles(16);
    checkOutput("t3_req_before_to", 256'(memReadReq), 256'd0);
    checkOutput("t3_busy_wait",     256'(busy), 256'd1);
    runCycles(1);
    checkOutput("t3_rereq", 256'(memReadReq), 256'd1);
    checkOutput("t3_rereq_addr", 256'(memReadAddress), 256'h3000);
    runCycles(1);
    applyStimulus(1'b1, 64'h3008, 1'b1, lineC);
    runCycles(1);
    applyStimulus(1'b1, 64'h3008, 1'b0, '0);
    checkOutput("t3_valid", 256'(refillValid), 256'd1);
    checkOutput("t3_instr", 256'(refillInstr), 256'hC000_0002);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(2);
    checkOutput("t3_reqs",   256'(reqCount), 256'd2);
    checkOutput("t3_valids", 256'(validCount), 256'd1);
    checkOutput("t3_errs",   256'(errCount), 256'd0);
    checkOutput("t3_idle",   256'(busy), 256'd0);

    $display("[TB] memory never answers");
    clearCounts();
    applyStimulus(1'b1, 64'h4000, 1'b0, '0);
    runCycles(1);
    runCycles(67);
    checkOutput("t4_reqs",      256'(reqCount), 256'd4);
    checkOutput("t4_no_err_yet", 256'(refillErr), 256'd0);
    checkOutput("t4_busy",      256'(busy), 256'd1);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    checkOutput("t4_err",       256'(refillErr), 256'd1);
    checkOutput("t4_no_valid",  256'(refillValid), 256'd0);
    runCycles(1);
    checkOutput("t4_err_pulse", 256'(refillErr), 256'd0);
    checkOutput("t4_idle",      256'(busy), 256'd0);
    runCycles(2);
    checkOutput("t4_reqs_final", 256'(reqCount), 256'd4);
    checkOutput("t4_errs",       256'(errCount), 256'd1);
    checkOutput("t4_valids",     256'(validCount), 256'd0);

    $display("[TB] stray done in IDLE, done on timeout cycle");
    applyStimulus(1'b0, 64'h0, 1'b1, lineJunk);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(1);
    checkOutput("t5_stray_busy",  256'(busy), 256'd0);
    checkOutput("t5_stray_valid", 256'(refillValid), 256'd0);
    checkOutput("t5_stray_line",  refillLine, lineC);
    clearCounts();
    applyStimulus(1'b1, 64'h5010, 1'b0, '0);
    runCycles(1);
    runCycles(16);
    applyStimulus(1'b1, 64'h5010, 1'b1, lineE);
    runCycles(1);
    applyStimulus(1'b1, 64'h5010, 1'b0, '0);
    checkOutput("t5_to_valid", 256'(refillValid), 256'd1);
    checkOutput("t5_to_noreq", 256'(memReadReq), 256'd0);
    checkOutput("t5_to_instr", 256'(refillInstr), 256'hE000_0004);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(2);
    checkOutput("t5_reqs", 256'(reqCount), 256'd1);
    checkOutput("t5_idle", 256'(busy), 256'd0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 64'h6000, 1'b0, '0);
    runCycles(4);
    checkOutput("t6_busy_before", 256'(busy), 256'd1);
    rst = 1'b1;
    runCycles(1);
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    checkOutput("t6_busy",  256'(busy), 256'd0);
    checkOutput("t6_maddr", 256'(memReadAddress), 256'd0);
    checkOutput("t6_line",  refillLine, 256'd0);
    checkOutput("t6_instr", 256'(refillInstr), 256'd0);
    checkOutput("t6_raddr", 256'(refillAddr), 256'd0);
    clearCounts();
    applyStimulus(1'b0, 64'h0, 1'b1, lineJunk);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(1);
    checkOutput("t6_late_valid", 256'(validCount), 256'd0);
    checkOutput("t6_late_line",  refillLine, 256'd0);
    applyStimulus(1'b1, 64'h7024, 1'b0, '0);
    runCycles(2);
    applyStimulus(1'b1, 64'h7024, 1'b1, lineF);
    runCycles(1);
    applyStimulus(1'b1, 64'h7024, 1'b0, '0);
    checkOutput("t6_valid", 256'(refillValid), 256'd1);
    checkOutput("t6_instr", 256'(refillInstr), 256'hF000_0001);
    checkOutput("t6_raddr", 256'(refillAddr), 256'h7020);
    runCycles(1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    runCycles(2);
    checkOutput("t6_idle", 256'(busy), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
